// File: rtl/priority_req_sched.sv
// Request scheduler in front of a 4-bit priority circuit: sticky pending bits,
// latched one-hot grant offered over valid/ready, then a programmable hold-off.
module priority_req_sched #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req_i,
    output logic [3:0] pend_o,
    input  logic [3:0] y_i,
    output logic       gnt_valid,
    input  logic       gnt_ready,
    output logic [3:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       busy,
    output logic       overflow
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] hold_cnt;
    logic [3:0] hold_cnt_nxt;
    logic [3:0] clr;
    logic       accept;
    logic       latch;

    function automatic logic [1:0] enc(input logic [3:0] oh);
        logic [1:0] idx;
        if (oh[3])
            idx = 2'd3;
        else if (oh[2])
            idx = 2'd2;
        else if (oh[1])
            idx = 2'd1;
        else
            idx = 2'd0;
        return idx;
    endfunction

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        latch        = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                if (pend_o != 4'd0) begin
                    latch     = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (gnt_ready) begin
                    accept       = 1'b1;
                    hold_cnt_nxt = HOLD_LOAD;
                    state_nxt    = (HOLD_CYCLES == 0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                // Leaving at a count of 1 makes HOLD last exactly HOLD_CYCLES cycles.
                if (hold_cnt <= 4'd1) begin
                    hold_cnt_nxt = 4'd0;
                    state_nxt    = IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                hold_cnt_nxt = 4'd0;
            end
        endcase
    end

    // A same-cycle re-request beats the clear, so it is neither lost nor an overflow.
    assign clr = accept ? gnt_onehot : 4'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= 4'd0;
            pend_o   <= 4'd0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
            pend_o   <= (pend_o & ~clr) | req_i;
            overflow <= |(req_i & pend_o & ~clr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_onehot <= 4'd0;
            gnt_idx    <= 2'd0;
        end else if (latch) begin
            gnt_onehot <= y_i;
            gnt_idx    <= enc(y_i);
        end
    end

    assign gnt_valid = (state == OFFER);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_priority_req_sched.sv
// Bench for priority_req_sched: two instances (hold 2 and hold 0) driven in
// lockstep and compared each cycle against a timing-rule reference model.
module tb_priority_req_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] req;
    logic       rdy;
    logic [3:0] pend [2];
    logic [3:0] y    [2];
    logic       gv   [2];
    logic       bz   [2];
    logic       ov   [2];
    logic [3:0] oh   [2];
    logic [1:0] ix   [2];

    function automatic logic [3:0] prio(input logic [3:0] a);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 3; k >= 0; k--)
            if (a[k] && r == 4'd0) r[k] = 1'b1;
        return r;
    endfunction

    assign y[0] = prio(pend[0]);
    assign y[1] = prio(pend[1]);

    priority_req_sched #(.HOLD_CYCLES(2)) dut_h2 (
        .clk(clk), .reset(reset), .req_i(req), .pend_o(pend[0]), .y_i(y[0]),
        .gnt_valid(gv[0]), .gnt_ready(rdy), .gnt_onehot(oh[0]), .gnt_idx(ix[0]),
        .busy(bz[0]), .overflow(ov[0])
    );

    priority_req_sched #(.HOLD_CYCLES(0)) dut_h0 (
        .clk(clk), .reset(reset), .req_i(req), .pend_o(pend[1]), .y_i(y[1]),
        .gnt_valid(gv[1]), .gnt_ready(rdy), .gnt_onehot(oh[1]), .gnt_idx(ix[1]),
        .busy(bz[1]), .overflow(ov[1])
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    int       hold_of  [2] = '{2, 0};
    bit [3:0] m_pend   [2];
    bit       m_off    [2];
    bit [3:0] m_oh     [2];
    int       m_idx    [2];
    int       m_idle_from [2];
    bit       m_ovf    [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 4'd0; m_off[i] = 1'b0; m_oh[i] = 4'd0;
            m_idx[i] = 0; m_idle_from[i] = 0; m_ovf[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d_pend", i), 32'(pend[i]), 32'(m_pend[i]));
            chk($sformatf("d%0d_valid", i), 32'(gv[i]), 32'(m_off[i]));
            chk($sformatf("d%0d_onehot", i), 32'(oh[i]), 32'(m_oh[i]));
            chk($sformatf("d%0d_idx", i), 32'(ix[i]), 32'(m_idx[i]));
            chk($sformatf("d%0d_busy", i), 32'(bz[i]), 32'(m_off[i] || cyc < m_idle_from[i]));
            chk($sformatf("d%0d_ovf", i), 32'(ov[i]), 32'(m_ovf[i]));
        end
    endtask

    // Grant may be taken once the hold window after the last accept has elapsed.
    task automatic model_advance(input logic [3:0] r, input logic rd);
        for (int i = 0; i < 2; i++) begin
            bit [3:0] c;
            c = (m_off[i] && rd) ? m_oh[i] : 4'd0;
            m_ovf[i] = |(r & m_pend[i] & ~c);
            if (m_off[i] && rd) begin
                m_off[i] = 1'b0;
                m_idle_from[i] = cyc + 1 + hold_of[i];
            end else if (!m_off[i] && cyc >= m_idle_from[i] && m_pend[i] != 4'd0) begin
                int top;
                top = 0;
                for (int k = 0; k < 4; k++) if (m_pend[i][k]) top = k;
                m_off[i] = 1'b1;
                m_oh[i]  = 4'd1 << top;
                m_idx[i] = top;
            end
            m_pend[i] = (m_pend[i] & ~c) | r;
        end
    endtask

    task automatic step(input logic [3:0] r, input logic rd);
        req = r;
        rdy = rd;
        #1;
        check_all();
        model_advance(r, rd);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'd0;
        rdy   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check_all();
        reset = 1'b0;
        cyc = 0;

        // Basic grant ordering and hold-off
        step(4'b0101, 1'b1);
        chk("t1_pend_c1", 32'(pend[0]), 32'h5);
        step(4'b0000, 1'b1);
        chk("t1_onehot_c2", 32'(oh[0]), 32'h4);
        chk("t1_idx_c2", 32'(ix[0]), 32'd2);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("t1_valid_c6", 32'(gv[0]), 32'd1);
        chk("t1_onehot_c6", 32'(oh[0]), 32'h1);
        for (int n = 0; n < 6; n++) step(4'b0000, 1'b1);

        // Backpressure with a higher-priority arrival during the offer
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        chk("t2_frozen", 32'(oh[0]), 32'h2);
        step(4'b0000, 1'b1);
        for (int n = 0; n < 8; n++) step(4'b0000, 1'b1);

        // Re-request in the accept cycle
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0010, 1'b1);
        chk("t3_pend_kept", 32'(pend[0][1]), 32'd1);
        chk("t3_no_ovf", 32'(ov[0]), 32'd0);
        for (int n = 0; n < 8; n++) step(4'b0000, 1'b1);

        // Duplicate request raises a one-cycle overflow
        step(4'b0001, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0001, 1'b0);
        chk("t4_ovf", 32'(ov[0]), 32'd1);
        step(4'b0000, 1'b0);
        chk("t4_ovf_drop", 32'(ov[0]), 32'd0);
        for (int n = 0; n < 6; n++) step(4'b0000, 1'b1);

        // Asynchronous reset during an offer
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b0);
        chk("t5_pre_valid", 32'(gv[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        for (int n = 0; n < 3; n++) step(4'b0000, 1'b0);

        // All four requests at once, zero hold-off
        step(4'b1111, 1'b1);
        step(4'b0000, 1'b1);
        chk("t6_first", 32'(oh[1]), 32'h8);
        for (int n = 0; n < 7; n++) step(4'b0000, 1'b1);
        chk("t6_drained", 32'(pend[1]), 32'h0);
        for (int n = 0; n < 8; n++) step(4'b0000, 1'b1);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            step(r, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
